vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Single-port access controller for the 2400-byte text VRAM; sits between the CPU data bus, the display character-fetch unit and the VRAM macro.
- Grants at most one VRAM access per clock, with display-first priority and a bounded CPU wait.
- Contains a hardware clear engine that fills the whole VRAM with a fill byte, replacing the testbench-only initialisation in the VRAM.

Parameters:
- MEMORY_BYTES, 2400: VRAM depth in bytes; valid addresses are 0..MEMORY_BYTES-1.
- ADDR_WIDTH, 12: width of all address ports.
- CPU_MAX_WAIT, 4: consecutive cycles a pending CPU request may lose to display before it is forced through.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held with its payload until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU byte address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle pulse: CPU request accepted (issued).
- cpu_rvalid  out  1  one-cycle pulse: rdata holds the CPU read result.
- disp_req  in  1  display read request; held with its payload until disp_ack.
- disp_addr  in  ADDR_WIDTH  display byte address.
- disp_ack  out  1  one-cycle pulse: display request accepted.
- disp_rvalid  out  1  one-cycle pulse: rdata holds the display read result.
- rdata  out  8  shared read data.
- clr_start  in  1  pulse: start the clear sweep.
- clr_fill  in  8  fill byte, sampled when clr_start is accepted.
- clr_busy  out  1  high while the sweep runs.
- clr_done  out  1  one-cycle pulse when the sweep finishes.
- vram_address  out  ADDR_WIDTH  registered VRAM address.
- vram_w_enable  out  1  registered VRAM write enable.
- vram_w_data  out  8  registered VRAM write data.
- vram_r_data  in  8  VRAM read data; the VRAM registers it on negedge.

Behaviour:
- Reset (async assert, sync deassert): every output 0. FSM = IDLE, wait counter = 0, clear pointer = 0. Reset during a sweep aborts it and leaves VRAM partially filled; clr_done is not pulsed.
- FSM states:
  - IDLE: the normal arbitration state.
  - CLEAR: entered on clr_start in IDLE. clr_fill is latched on entry.
  - CLEAR behaviour: one write per cycle to addresses 0..MEMORY_BYTES-1 with the latched fill byte.
  - CLEAR exit: after the last write is issued, return to IDLE and pulse clr_done for one cycle.
  - clr_busy = (state == CLEAR).
  - clr_start while in CLEAR is ignored.
  - In CLEAR, no cpu_ack or disp_ack is issued. Requests stay pending.
- Arbitration in IDLE, evaluated each posedge T:
  - If cpu_req and wait counter == CPU_MAX_WAIT: CPU is granted.
  - Else if disp_req: display is granted.
  - Else if cpu_req: CPU is granted.
  - clr_start has priority over both requesters in the same cycle: go to CLEAR, no ack.
  - Wait counter: increments, saturating, each cycle cpu_req is pending and not granted; clears on cpu_ack.
- Grant at edge T:
  - The ack pulses in cycle T..T+1.
  - vram_address, vram_w_enable and vram_w_data are registered at T.
  - The VRAM write lands at posedge T+1.
- Read latency:
  - The read address is registered at T; the VRAM samples it on the following negedge.
  - At edge T+1, cpu_rvalid or disp_rvalid is asserted for one cycle.
  - rdata = vram_r_data (passthrough) while rvalid is high.
  - Back-to-back grants give one read result per cycle.
- Idle cycles: vram_w_enable = 0. vram_address holds its last value.
- Out of range (addr >= MEMORY_BYTES):
  - The access is still acked.
  - A write is suppressed: vram_w_enable = 0.
  - A read gets its normal rvalid one cycle later, with rdata forced to 8'h00.
- Read-after-write: a CPU write granted at T followed by a display read of the same address granted at T+1 returns the new data.
- Address width: cpu_addr and disp_addr are compared unsigned against MEMORY_BYTES. The clear pointer wraps to 0 on exit.

Test Plan:
- Reset, then CPU write 0x5A to 0x010, then CPU read 0x010 -> cpu_ack in each grant cycle; cpu_rvalid one cycle after the read grant with rdata = 0x5A.
- disp_req held continuously with incrementing addresses, and cpu_req read of 0x020 pending -> CPU loses 4 cycles, is granted on the 5th, and the display resumes the next cycle.
- Simultaneous cpu_req and disp_req with wait counter at 0 -> display acked first; CPU acked the following cycle.
- clr_start with clr_fill = 0xFF while both requesters are active -> clr_busy high for 2400 cycles, no acks, clr_done pulses once; display reads of 0 and 2399 afterwards return 0xFF.
- CPU write to 2400 and read of 4095 -> both acked; no vram_w_enable; the read returns rdata = 0x00 with cpu_rvalid.
- rst_n asserted mid-clear at pointer 1000 -> all outputs 0 immediately; state IDLE; no clr_done; a CPU request is served normally afterwards.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - CPU, display, clear and VRAM macro signals of the VRAM arbiter
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  // CPU data bus
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [7:0]            cpu_wdata;
  logic                  cpu_ack;
  logic                  cpu_rvalid;
  // display character fetch
  logic                  disp_req;
  logic [ADDR_WIDTH-1:0] disp_addr;
  logic                  disp_ack;
  logic                  disp_rvalid;
  // shared read data
  logic [7:0]            rdata;
  // clear engine
  logic                  clr_start;
  logic [7:0]            clr_fill;
  logic                  clr_busy;
  logic                  clr_done;
  // VRAM macro
  logic [ADDR_WIDTH-1:0] vram_address;
  logic                  vram_w_enable;
  logic [7:0]            vram_w_data;
  logic [7:0]            vram_r_data;

  // requesters and VRAM macro side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output disp_req, disp_addr,
    output clr_start, clr_fill,
    output vram_r_data,
    input  cpu_ack, cpu_rvalid, disp_ack, disp_rvalid, rdata,
    input  clr_busy, clr_done,
    input  vram_address, vram_w_enable, vram_w_data
  );

  // arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  disp_req, disp_addr,
    input  clr_start, clr_fill,
    input  vram_r_data,
    output cpu_ack, cpu_rvalid, disp_ack, disp_rvalid, rdata,
    output clr_busy, clr_done,
    output vram_address, vram_w_enable, vram_w_data
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port text VRAM arbiter with display priority, bounded CPU wait and clear engine
module vram_arbiter #(
  parameter int MEMORY_BYTES = 2400,
  parameter int ADDR_WIDTH   = 12,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  vram_arbiter_if.slave bus
);

  localparam int                   WAIT_W    = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_MAX  = WAIT_W'(CPU_MAX_WAIT);
  localparam logic [ADDR_WIDTH:0]  MEM_LIMIT = (ADDR_WIDTH + 1)'(MEMORY_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_BYTES - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]            fill_q, fill_d;

  logic                  grant_cpu, grant_disp, clr_done_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [7:0]            wdata_d;
  logic                  rd_cpu_d, rd_disp_d, rd_oor_d;

  logic                  cpu_ack_q, disp_ack_q, clr_done_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;
  // read issued at the last edge; the VRAM samples its address on the coming negedge
  logic                  rd_cpu_q, rd_disp_q, rd_oor_q;
  // read result presented this cycle
  logic                  cpu_rvalid_q, disp_rvalid_q, rvalid_oor_q;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < MEM_LIMIT;
  endfunction

  // Arbitration, clear sweep sequencing and next VRAM command
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    ptr_d      = ptr_q;
    fill_d     = fill_q;
    grant_cpu  = 1'b0;
    grant_disp = 1'b0;
    clr_done_d = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_cpu_d   = 1'b0;
    rd_disp_d  = 1'b0;
    rd_oor_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d = CLEAR;
          fill_d  = bus.clr_fill;
          ptr_d   = '0;
        end else if (bus.cpu_req && (wait_q == WAIT_MAX)) begin
          grant_cpu = 1'b1;
        end else if (bus.disp_req) begin
          grant_disp = 1'b1;
        end else if (bus.cpu_req) begin
          grant_cpu = 1'b1;
        end
      end
      CLEAR: begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = fill_q;
        if (ptr_q == LAST_ADDR) begin
          state_d    = IDLE;
          ptr_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_cpu) begin
      addr_d   = bus.cpu_addr;
      wdata_d  = bus.cpu_wdata;
      // out-of-range writes are acknowledged but never reach the macro
      we_d     = bus.cpu_we && in_range(bus.cpu_addr);
      rd_cpu_d = !bus.cpu_we;
      rd_oor_d = !bus.cpu_we && !in_range(bus.cpu_addr);
    end
    if (grant_disp) begin
      addr_d    = bus.disp_addr;
      rd_disp_d = 1'b1;
      rd_oor_d  = !in_range(bus.disp_addr);
    end

    // the wait count keeps climbing through a sweep, so the CPU goes first afterwards
    if (grant_cpu) begin
      wait_d = '0;
    end else if (bus.cpu_req && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // FSM and sweep state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      ptr_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
    end
  end

  // Registered VRAM command, ack pulses and the read-valid pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ack_q     <= 1'b0;
      disp_ack_q    <= 1'b0;
      clr_done_q    <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_cpu_q      <= 1'b0;
      rd_disp_q     <= 1'b0;
      rd_oor_q      <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      disp_rvalid_q <= 1'b0;
      rvalid_oor_q  <= 1'b0;
    end else begin
      cpu_ack_q     <= grant_cpu;
      disp_ack_q    <= grant_disp;
      clr_done_q    <= clr_done_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_cpu_q      <= rd_cpu_d;
      rd_disp_q     <= rd_disp_d;
      rd_oor_q      <= rd_oor_d;
      cpu_rvalid_q  <= rd_cpu_q;
      disp_rvalid_q <= rd_disp_q;
      rvalid_oor_q  <= rd_oor_q;
    end
  end

  assign bus.cpu_ack       = cpu_ack_q;
  assign bus.disp_ack      = disp_ack_q;
  assign bus.cpu_rvalid    = cpu_rvalid_q;
  assign bus.disp_rvalid   = disp_rvalid_q;
  assign bus.clr_busy      = (state_q == CLEAR);
  assign bus.clr_done      = clr_done_q;
  assign bus.vram_address  = addr_q;
  assign bus.vram_w_enable = we_q;
  assign bus.vram_w_data   = wdata_q;
  // macro data passes straight through while a result is valid; out-of-range reads return zero
  assign bus.rdata = ((cpu_rvalid_q || disp_rvalid_q) && !rvalid_oor_q) ? bus.vram_r_data : 8'h00;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;
  localparam int MEMORY_BYTES = 2400;
  localparam int ADDR_WIDTH   = 12;
  localparam int CPU_MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  vram_arbiter #(
    .MEMORY_BYTES(MEMORY_BYTES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .CPU_MAX_WAIT(CPU_MAX_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // VRAM macro: writes on posedge, registers read data on negedge
  logic [7:0] vmem [0:4095];
  always @(posedge clk) if (bus.vram_w_enable) vmem[bus.vram_address] <= bus.vram_w_data;
  always @(negedge clk) bus.vram_r_data <= vmem[bus.vram_address];

  int n_checks, n_fail;

  // reference model state
  logic [7:0]            shadow [0:MEMORY_BYTES-1];
  int                    wait_cnt, clear_left;
  logic [7:0]            clear_fill;
  bit                    pend_c, pend_d;
  logic [7:0]            pend_val;
  bit                    exp_cpu_ack, exp_disp_ack, exp_we, exp_addr_ok, exp_done, exp_busy;
  bit                    exp_cpu_rvalid, exp_disp_rvalid;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic [7:0]            exp_wdata, exp_rdata;

  function automatic logic [34:0] outs();
    return {bus.cpu_ack, bus.cpu_rvalid, bus.disp_ack, bus.disp_rvalid, bus.rdata, bus.clr_busy,
            bus.clr_done, bus.vram_address, bus.vram_w_enable, bus.vram_w_data};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return ADDR_WIDTH'($urandom_range(0, 15));
      2:       return ADDR_WIDTH'($urandom_range(0, MEMORY_BYTES - 1));
      default: return ADDR_WIDTH'($urandom_range(MEMORY_BYTES - 8, 4095));
    endcase
  endfunction

  function automatic logic [7:0] model_read(input logic [ADDR_WIDTH-1:0] a);
    if (int'(a) < MEMORY_BYTES) return shadow[a];
    return 8'h00;
  endfunction

  task automatic model_reset();
    wait_cnt = 0; clear_left = 0; pend_c = 0; pend_d = 0; pend_val = 8'h00;
  endtask

  // Predict the outcome of the coming edge from the current inputs, then advance one cycle
  task automatic tick();
    bit g_cpu, g_disp, rd_c, rd_d;
    logic [7:0] rd_val;
    g_cpu = 0; g_disp = 0; rd_c = 0; rd_d = 0; rd_val = 8'h00;
    exp_we = 0; exp_addr_ok = 0; exp_done = 0;
    if (clear_left > 0) begin
      exp_we = 1; exp_addr_ok = 1;
      exp_addr = ADDR_WIDTH'(MEMORY_BYTES - clear_left);
      exp_wdata = clear_fill;
      clear_left--;
      exp_done = (clear_left == 0);
    end else if (bus.clr_start) begin
      clear_left = MEMORY_BYTES;
      clear_fill = bus.clr_fill;
      foreach (shadow[i]) shadow[i] = bus.clr_fill;
    end else if (bus.cpu_req && (wait_cnt == CPU_MAX_WAIT || !bus.disp_req)) g_cpu = 1;
    else if (bus.disp_req) g_disp = 1;
    if (g_cpu) begin
      exp_addr_ok = 1; exp_addr = bus.cpu_addr;
      if (bus.cpu_we) begin
        if (int'(bus.cpu_addr) < MEMORY_BYTES) begin
          exp_we = 1; exp_wdata = bus.cpu_wdata; shadow[bus.cpu_addr] = bus.cpu_wdata;
        end
      end else begin
        rd_c = 1; rd_val = model_read(bus.cpu_addr);
      end
    end
    if (g_disp) begin
      exp_addr_ok = 1; exp_addr = bus.disp_addr; rd_d = 1; rd_val = model_read(bus.disp_addr);
    end
    if (g_cpu) wait_cnt = 0;
    else if (bus.cpu_req && wait_cnt < CPU_MAX_WAIT) wait_cnt++;
    exp_cpu_rvalid = pend_c; exp_disp_rvalid = pend_d; exp_rdata = pend_val;
    pend_c = rd_c; pend_d = rd_d; pend_val = rd_val;
    exp_cpu_ack = g_cpu; exp_disp_ack = g_disp; exp_busy = (clear_left > 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (outs() !== 35'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs()); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (outs() !== 35'd0) begin n_fail++; $display("FAIL post_reset_idle: got %h want 0", outs()); end
  endtask

  task automatic test_cpu_write_read();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h010; bus.cpu_wdata = 8'h5A;
    tick();
    n_checks++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", bus.cpu_ack); end
    n_checks++; if ({bus.vram_w_enable, bus.vram_address, bus.vram_w_data} !== {1'b1, 12'h010, 8'h5A}) begin
      n_fail++; $display("FAIL wr_cmd: got we=%b a=%h d=%h want we=1 a=010 d=5a", bus.vram_w_enable, bus.vram_address, bus.vram_w_data); end
    bus.cpu_req = 0; bus.cpu_we = 0;
    tick();
    n_checks++; if ({bus.cpu_ack, bus.vram_w_enable} !== 2'b00) begin n_fail++; $display("FAIL idle_after_wr: got ack=%b we=%b want 0 0", bus.cpu_ack, bus.vram_w_enable); end
    bus.cpu_req = 1; bus.cpu_addr = 12'h010;
    tick();
    n_checks++; if ({bus.cpu_ack, bus.cpu_rvalid} !== 2'b10) begin n_fail++; $display("FAIL rd_ack: got ack=%b rvalid=%b want 1 0", bus.cpu_ack, bus.cpu_rvalid); end
    bus.cpu_req = 0;
    tick();
    n_checks++; if ({bus.cpu_rvalid, bus.rdata} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL rd_data: got rvalid=%b rdata=%h want 1 5a", bus.cpu_rvalid, bus.rdata); end
  endtask

  task automatic test_cpu_starvation();
    logic [7:0] want;
    want = shadow[12'h020];
    bus.disp_req = 1; bus.disp_addr = 12'd100;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h020;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_checks++;
      if ({bus.cpu_ack, bus.disp_ack} !== ((c == 5) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL starve_cycle%0d: got cpu_ack=%b disp_ack=%b", c, bus.cpu_ack, bus.disp_ack); end
      if (c == 5) bus.cpu_req = 0;
      else bus.disp_addr = bus.disp_addr + 1'b1;
      if (c == 6) begin
        n_checks++; if ({bus.cpu_rvalid, bus.rdata} !== {1'b1, want}) begin
          n_fail++; $display("FAIL starve_rdata: got rvalid=%b rdata=%h want 1 %h", bus.cpu_rvalid, bus.rdata, want); end
      end
    end
    bus.disp_req = 0;
    tick(); tick();
  endtask

  task automatic test_simultaneous();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h030;
    bus.disp_req = 1; bus.disp_addr = 12'h031;
    tick();
    n_checks++; if ({bus.cpu_ack, bus.disp_ack} !== 2'b01) begin n_fail++; $display("FAIL simul_first: got cpu=%b disp=%b want 0 1", bus.cpu_ack, bus.disp_ack); end
    bus.disp_req = 0;
    tick();
    n_checks++; if ({bus.cpu_ack, bus.disp_ack} !== 2'b10) begin n_fail++; $display("FAIL simul_second: got cpu=%b disp=%b want 1 0", bus.cpu_ack, bus.disp_ack); end
    n_checks++; if ({bus.disp_rvalid, bus.rdata} !== {1'b1, shadow[12'h031]}) begin n_fail++; $display("FAIL simul_disp_data: got %b %h want 1 %h", bus.disp_rvalid, bus.rdata, shadow[12'h031]); end
    bus.cpu_req = 0;
    tick();
    n_checks++; if ({bus.cpu_rvalid, bus.rdata} !== {1'b1, shadow[12'h030]}) begin n_fail++; $display("FAIL simul_cpu_data: got %b %h want 1 %h", bus.cpu_rvalid, bus.rdata, shadow[12'h030]); end
  endtask

  task automatic test_out_of_range();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'd2400; bus.cpu_wdata = 8'h77;
    tick();
    n_checks++; if ({bus.cpu_ack, bus.vram_w_enable} !== 2'b10) begin n_fail++; $display("FAIL oor_wr: got ack=%b we=%b want 1 0", bus.cpu_ack, bus.vram_w_enable); end
    bus.cpu_req = 0; bus.cpu_we = 0;
    tick();
    bus.cpu_req = 1; bus.cpu_addr = 12'd4095;
    tick();
    n_checks++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL oor_rd_ack: got %b want 1", bus.cpu_ack); end
    bus.cpu_req = 0;
    tick();
    n_checks++; if ({bus.cpu_rvalid, bus.rdata} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL oor_cpu_rd: got %b %h want 1 00", bus.cpu_rvalid, bus.rdata); end
    bus.disp_req = 1; bus.disp_addr = 12'd2400;
    tick();
    bus.disp_req = 0;
    tick();
    n_checks++; if ({bus.disp_rvalid, bus.rdata} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL oor_disp_rd: got %b %h want 1 00", bus.disp_rvalid, bus.rdata); end
    n_checks++; if (vmem[2400] !== 8'h3E) begin n_fail++; $display("FAIL oor_wr_suppressed: got %h want 3e", vmem[2400]); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 620; cyc++) begin
      if (cyc < 600 && !bus.cpu_req && $urandom_range(0, 1) == 1) begin
        bus.cpu_req = 1; bus.cpu_we = 1'($urandom_range(0, 1)); bus.cpu_addr = rand_addr(); bus.cpu_wdata = 8'($urandom);
      end
      if (cyc < 600 && !bus.disp_req && $urandom_range(0, 2) != 0) begin
        bus.disp_req = 1; bus.disp_addr = rand_addr();
      end
      tick();
      n_checks++; if ({bus.cpu_ack, bus.disp_ack} !== {exp_cpu_ack, exp_disp_ack}) begin
        n_fail++; $display("FAIL rand_ack c%0d: got %b%b want %b%b", cyc, bus.cpu_ack, bus.disp_ack, exp_cpu_ack, exp_disp_ack); end
      n_checks++; if (bus.vram_w_enable !== exp_we) begin
        n_fail++; $display("FAIL rand_we c%0d: got %b want %b", cyc, bus.vram_w_enable, exp_we); end
      if (exp_addr_ok) begin
        n_checks++; if (bus.vram_address !== exp_addr) begin n_fail++; $display("FAIL rand_addr c%0d: got %h want %h", cyc, bus.vram_address, exp_addr); end
      end
      if (exp_we) begin
        n_checks++; if (bus.vram_w_data !== exp_wdata) begin n_fail++; $display("FAIL rand_wdata c%0d: got %h want %h", cyc, bus.vram_w_data, exp_wdata); end
      end
      n_checks++; if ({bus.cpu_rvalid, bus.disp_rvalid} !== {exp_cpu_rvalid, exp_disp_rvalid}) begin
        n_fail++; $display("FAIL rand_rvalid c%0d: got %b%b want %b%b", cyc, bus.cpu_rvalid, bus.disp_rvalid, exp_cpu_rvalid, exp_disp_rvalid); end
      if (exp_cpu_rvalid || exp_disp_rvalid) begin
        n_checks++; if (bus.rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata c%0d: got %h want %h", cyc, bus.rdata, exp_rdata); end
      end
      if (exp_cpu_ack) bus.cpu_req = 0;
      if (exp_disp_ack) bus.disp_req = 0;
    end
  endtask

  task automatic test_clear();
    int busy_cycles, acks, dones, bad;
    bit seen_done;
    busy_cycles = 0; acks = 0; dones = 0; bad = 0; seen_done = 0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h040;
    bus.disp_req = 1; bus.disp_addr = 12'd0;
    bus.clr_start = 1; bus.clr_fill = 8'hFF;
    tick();
    bus.clr_start = 0; bus.clr_fill = 8'h00;
    for (int k = 0; k < 2600; k++) begin
      if (bus.clr_busy) busy_cycles++;
      if (bus.cpu_ack || bus.disp_ack) acks++;
      if (bus.clr_done) begin dones++; seen_done = 1; break; end
      if (k == 5) bus.clr_start = 1;
      if (k == 6) bus.clr_start = 0;
      tick();
    end
    n_checks++; if (!seen_done) begin n_fail++; $display("FAIL clr_done_timeout: no clr_done within 2600 cycles"); end
    n_checks++; if (busy_cycles != MEMORY_BYTES) begin n_fail++; $display("FAIL clr_busy_len: got %0d want %0d", busy_cycles, MEMORY_BYTES); end
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL clr_no_acks: got %0d acks want 0", acks); end
    tick();
    if (bus.clr_done) dones++;
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL clr_done_once: got %0d pulses want 1", dones); end
    n_checks++; if ({bus.cpu_ack, bus.disp_ack} !== 2'b10) begin n_fail++; $display("FAIL clr_cpu_first: got %b%b want 10", bus.cpu_ack, bus.disp_ack); end
    bus.cpu_req = 0;
    tick();
    n_checks++; if ({bus.disp_ack, bus.cpu_rvalid, bus.rdata} !== {2'b11, 8'hFF}) begin
      n_fail++; $display("FAIL clr_cpu_rd: got ack=%b rv=%b d=%h want 1 1 ff", bus.disp_ack, bus.cpu_rvalid, bus.rdata); end
    bus.disp_addr = 12'd2399;
    tick();
    n_checks++; if ({bus.disp_ack, bus.disp_rvalid, bus.rdata} !== {2'b11, 8'hFF}) begin
      n_fail++; $display("FAIL clr_disp_rd0: got ack=%b rv=%b d=%h want 1 1 ff", bus.disp_ack, bus.disp_rvalid, bus.rdata); end
    bus.disp_req = 0;
    tick();
    n_checks++; if ({bus.disp_rvalid, bus.rdata} !== {1'b1, 8'hFF}) begin
      n_fail++; $display("FAIL clr_disp_rd2399: got rv=%b d=%h want 1 ff", bus.disp_rvalid, bus.rdata); end
    for (int i = 0; i < MEMORY_BYTES; i++) if (vmem[i] !== 8'hFF) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clr_fill_all: got %0d bytes not ff want 0", bad); end
  endtask

  task automatic test_reset_mid_clear();
    bit found;
    int dones;
    found = 0; dones = 0;
    bus.clr_start = 1; bus.clr_fill = 8'h3C;
    tick();
    bus.clr_start = 0;
    for (int k = 0; k < 1200; k++) begin
      if (bus.vram_w_enable && bus.vram_address == 12'd1000) begin found = 1; break; end
      tick();
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL midclr_reach: pointer 1000 not reached within 1200 cycles"); end
    #2 rst_n = 1'b0; model_reset();
    #1;
    n_checks++; if (outs() !== 35'd0) begin n_fail++; $display("FAIL midclr_async_reset: got %h want 0", outs()); end
    repeat (3) begin @(posedge clk); #1; if (bus.clr_done || bus.clr_busy) dones++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (bus.clr_done || bus.clr_busy) dones++; end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midclr_no_done: got %0d busy/done cycles want 0", dones); end
    n_checks++; if ({vmem[999], vmem[1000], vmem[1500]} !== {8'h3C, 8'hFF, 8'hFF}) begin
      n_fail++; $display("FAIL midclr_partial: got %h %h %h want 3c ff ff", vmem[999], vmem[1000], vmem[1500]); end
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h123; bus.cpu_wdata = 8'h99;
    tick();
    n_checks++; if ({bus.cpu_ack, bus.vram_w_enable} !== 2'b11) begin n_fail++; $display("FAIL midclr_wr: got ack=%b we=%b want 1 1", bus.cpu_ack, bus.vram_w_enable); end
    bus.cpu_we = 0;
    tick();
    n_checks++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL midclr_rd_ack: got %b want 1", bus.cpu_ack); end
    bus.cpu_req = 0;
    tick();
    n_checks++; if ({bus.cpu_rvalid, bus.rdata} !== {1'b1, 8'h99}) begin n_fail++; $display("FAIL midclr_rd: got %b %h want 1 99", bus.cpu_rvalid, bus.rdata); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.disp_req = 0; bus.disp_addr = '0; bus.clr_start = 0; bus.clr_fill = '0;
    for (int i = 0; i < MEMORY_BYTES; i++) begin
      shadow[i] = 8'($urandom);
      vmem[i] <= shadow[i];
    end
    for (int i = MEMORY_BYTES; i < 4096; i++) vmem[i] <= 8'($urandom_range(1, 255));
    vmem[2400] <= 8'h3E;
    vmem[4095] <= 8'hA5;
    test_reset();
    test_cpu_write_read();
    test_cpu_starvation();
    test_simultaneous();
    test_out_of_range();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
